// File: rtl/coord_shader.sv
// Per-pixel shader: a filled circle at the origin over a checkerboard background.
// Three-stage elastic pipeline. One global enable advances every stage when the output slot is free.
module coord_shader #(
    parameter int          RADIUS      = 100,
    parameter int          CHECK_SHIFT = 5,
    parameter logic [23:0] FG_COLOR    = 24'hFFFFFF,
    parameter logic [23:0] BG0_COLOR   = 24'h202020,
    parameter logic [23:0] BG1_COLOR   = 24'h404040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic        in_first,
    input  logic        in_lastx,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] out_pixel,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] frame_count
);

    localparam logic [32:0] RADIUS_SQ = 33'(RADIUS) * 33'(RADIUS);

    logic        adv;
    logic [2:0]  valid_reg;

    logic [15:0] x1_reg, y1_reg;
    logic [31:0] xx1_reg, yy1_reg;
    logic        first1_reg, last1_reg;

    logic [32:0] sum2_reg;
    logic        inside2_reg, parity2_reg, first2_reg, last2_reg;

    logic [23:0] pixel_reg;
    logic        sof_reg, eol_reg;
    logic [15:0] frame_count_reg;

    logic [31:0] x_ext, y_ext;
    logic [31:0] xx_next, yy_next;
    logic [32:0] sum_next;
    logic signed [15:0] tile_x, tile_y;
    logic        parity_next;
    logic [23:0] pixel_next;

    assign adv         = !valid_reg[2] || out_ready;
    assign in_ready    = adv;
    assign out_valid   = valid_reg[2];
    assign out_pixel   = pixel_reg;
    assign out_sof     = sof_reg;
    assign out_eol     = eol_reg;
    assign frame_count = frame_count_reg;

    // Sign-extend before squaring so the low 32 product bits are the exact square.
    assign x_ext    = {{16{in_x[15]}}, in_x};
    assign y_ext    = {{16{in_y[15]}}, in_y};
    assign xx_next  = x_ext * x_ext;
    assign yy_next  = y_ext * y_ext;
    assign sum_next = {1'b0, xx1_reg} + {1'b0, yy1_reg};

    assign tile_x      = $signed(x1_reg) >>> CHECK_SHIFT;
    assign tile_y      = $signed(y1_reg) >>> CHECK_SHIFT;
    assign parity_next = tile_x[0] ^ tile_y[0];

    always_comb begin
        pixel_next = parity2_reg ? BG1_COLOR : BG0_COLOR;
        if (inside2_reg) begin
            pixel_next = FG_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg       <= '0;
            x1_reg          <= '0;
            y1_reg          <= '0;
            xx1_reg         <= '0;
            yy1_reg         <= '0;
            first1_reg      <= 1'b0;
            last1_reg       <= 1'b0;
            sum2_reg        <= '0;
            inside2_reg     <= 1'b0;
            parity2_reg     <= 1'b0;
            first2_reg      <= 1'b0;
            last2_reg       <= 1'b0;
            pixel_reg       <= '0;
            sof_reg         <= 1'b0;
            eol_reg         <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            if (adv) begin
                valid_reg   <= {valid_reg[1:0], in_valid};
                x1_reg      <= in_x;
                y1_reg      <= in_y;
                xx1_reg     <= xx_next;
                yy1_reg     <= yy_next;
                first1_reg  <= in_first;
                last1_reg   <= in_lastx;
                sum2_reg    <= sum_next;
                inside2_reg <= (sum_next <= RADIUS_SQ);
                parity2_reg <= parity_next;
                first2_reg  <= first1_reg;
                last2_reg   <= last1_reg;
                pixel_reg   <= pixel_next;
                sof_reg     <= first2_reg;
                eol_reg     <= last2_reg;
            end
            if (valid_reg[2] && out_ready && sof_reg) begin
                frame_count_reg <= frame_count_reg + 16'd1;
            end
        end
    end

endmodule
